ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
Upstream feeder for the configuration-chain flip-flops of the IO and logic tiles. Accepts the bitstream as a byte stream over a valid/ready handshake and serializes it MSB-first onto the head of the chain (ccff_head). Drives a clock-enable that the tile-level clock gate uses to gate prog_clk. The chain therefore advances exactly once per valid bit, and handshake stalls never shift garbage into it.

Parameters:
CHAIN_LEN, 1024, total configuration bits in the chain (>=1)
DATA_W, 8, byte-stream width in bits (>=2)

Ports:
prog_clk  input  1  programming clock; the only clock
pReset  input  1  asynchronous active-high reset
start  input  1  single-cycle request to begin a load; ignored while busy=1
byte_valid  input  1  byte_data is valid
byte_data  input  DATA_W  bitstream byte; bit DATA_W-1 is shifted first
byte_ready  output  1  loader can accept a byte this cycle
ccff_head  output  1  serial data to the first chain flip-flop
ccff_clk_en  output  1  chain captures ccff_head at the end of every cycle where this is 1
busy  output  1  a load is in progress
done  output  1  last load completed; held until the next accepted start
err  output  1  CRC mismatch on the last load (optional feature only)

Behaviour:
- One clock (prog_clk). Reset is asynchronous and active-high (pReset). All outputs are registered.
- Reset values: byte_ready=0, ccff_head=0, ccff_clk_en=0, busy=0, done=0, err=0, state=IDLE, all counters=0.
- Bytes per load: NB = ceil(CHAIN_LEN/DATA_W). In the last byte only the top R bits are used, where R = CHAIN_LEN - (NB-1)*DATA_W. Its lower bits are discarded.
- State IDLE: byte_ready=0. On start=1, go to LOAD; busy<=1, done<=0, err<=0, bit_cnt<=0.
- State LOAD: byte_ready=1, ccff_clk_en=0. On byte_valid&byte_ready:
  - shreg <= byte_data<<1
  - ccff_head <= byte_data[DATA_W-1]
  - ccff_clk_en <= 1
  - nbits <= (last byte ? R : DATA_W) - 1
  - go to SHIFT
- State SHIFT: byte_ready=0, and one bit is presented per cycle with ccff_clk_en=1. Each cycle:
  - bit_cnt increments
  - if nbits>0: ccff_head <= shreg[DATA_W-1], shreg <<= 1, nbits--
  - otherwise: ccff_clk_en <= 0, then go to LOAD if bit_cnt+1 < CHAIN_LEN, else DONE (or CRC when the optional feature is compiled in)
- Latency: the first bit of an accepted byte is on ccff_head with ccff_clk_en=1 in the cycle after acceptance.
- Throughput: DATA_W+1 cycles per full byte (the handshake cycle has ccff_clk_en=0).
- Invariant: the number of ccff_clk_en=1 cycles per load is exactly CHAIN_LEN, with no extra enables during stalls.
- State DONE: busy<=0, done<=1, go to IDLE.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle that DONE returns to IDLE: not accepted until the IDLE cycle.
  - byte_valid while in IDLE: ignored; byte_ready=0.
  - pReset mid-load: immediate return to reset values. Chain contents are undefined and software must reload.
  - CHAIN_LEN < DATA_W: NB=1, R=CHAIN_LEN.
- Width rules: bit_cnt is $clog2(CHAIN_LEN+1) bits wide; nbits is $clog2(DATA_W) bits wide. No counter may wrap within a load.

Optional Feature:
Macro CCFF_LOADER_CRC_EN.
- Defined:
  - A CRC-8 (polynomial x^8+x^2+x+1, init 0x00) is updated with every bit presented while ccff_clk_en=1.
  - After the last chain bit, state CRC asserts byte_ready and accepts one further byte, which is not shifted and never raises ccff_clk_en.
  - err <= (byte_data[7:0] != crc), then go to DONE.
  - Requires DATA_W>=8.
- Undefined: no CRC state and no trailer byte; err is tied to 0.

Decomposition:
- Shared package ccff_loader_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, CRC, DONE)
  - the CRC-8 polynomial constant
  - a function computing NB and R from CHAIN_LEN and DATA_W
- One sub-module, ccff_crc8_serial: 1-bit-per-cycle CRC-8 with enable and clear, instantiated only under CCFF_LOADER_CRC_EN.

Test Plan:
- Reset: assert pReset mid-cycle -> all outputs 0 asynchronously; state IDLE.
- Basic load (CHAIN_LEN=12, DATA_W=8): start, then bytes 0xA5, 0x3F with valid held high -> exactly 12 ccff_clk_en cycles with ccff_head 1,0,1,0,0,1,0,1,0,0,1,1; done=1; busy=0; a 12-deep shift-register model of the chain matches.
- Backpressure: same load with byte_valid low for 5 cycles between the bytes -> ccff_clk_en stays 0 during the gap, total enables still 12, chain model identical.
- Start while busy: pulse start during SHIFT -> ignored; done rises once, after the 12th bit.
- Reset mid-load: pReset after 5 enabled bits -> outputs 0; a new start plus a full load succeeds, with 12 enables counted from the restart.
- CRC (macro defined, CHAIN_LEN=16): bytes 0x12, 0x34, then the correct CRC-8 of those 16 bits -> err=0. Repeat with the trailer XOR 0x01 -> err=1, done=1, no extra ccff_clk_en.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
// Used by ccff_bitstream_loader and ccff_crc8_serial.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CRC,
        DONE
    } state_t;

    // x^8 + x^2 + x + 1
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef struct packed {
        int unsigned nb;
        int unsigned r;
    } geom_t;

    // nb: bytes per load; r: bits used from the final byte
    function automatic geom_t chain_geom(int unsigned chain_len,
                                         int unsigned data_w);
        geom_t g;
        g.nb = (chain_len + data_w - 1) / data_w;
        g.r  = chain_len - (g.nb - 1) * data_w;
        return g;
    endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 (MSB-first, init 0x00) with synchronous clear.
// Only instantiated when CCFF_LOADER_CRC_EN is defined.
module ccff_crc8_serial
    import ccff_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[7] ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ ({8{fb}} & CRC8_POLY);
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Byte-stream to config-chain serializer with gated chain clock enable.
// Optional CRC-8 trailer check when CCFF_LOADER_CRC_EN is defined.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int    CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int    NB_W  = $clog2(DATA_W);
    localparam geom_t GEOM  = chain_geom(CHAIN_LEN, DATA_W);

    localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'((GEOM.nb - 1) * DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [NB_W-1:0]  NB_FULL   = NB_W'(DATA_W - 1);
    localparam logic [NB_W-1:0]  NB_LAST   = NB_W'(GEOM.r - 1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic [NB_W-1:0]   nbits, nbits_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic              head_nx, en_nx, busy_nx, done_nx, ready_nx;
    logic              accept;

    assign accept = byte_valid & byte_ready;

`ifdef CCFF_LOADER_CRC_EN
    logic       err_q, err_nx;
    logic       crc_clr;
    logic [7:0] crc;

    assign crc_clr = (state == IDLE) & start;
    assign err     = err_q;

    // Tracks exactly the bits the chain captures
    ccff_crc8_serial u_crc (
        .clk (prog_clk),
        .rst (pReset),
        .clr (crc_clr),
        .en  (ccff_clk_en),
        .din (ccff_head),
        .crc (crc)
    );
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        nbits_nx   = nbits;
        bit_cnt_nx = bit_cnt;
        head_nx    = ccff_head;
        en_nx      = ccff_clk_en;
        busy_nx    = busy;
        done_nx    = done;
        ready_nx   = byte_ready;
`ifdef CCFF_LOADER_CRC_EN
        err_nx     = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = LOAD;
                    busy_nx    = 1'b1;
                    done_nx    = 1'b0;
                    bit_cnt_nx = '0;
                    ready_nx   = 1'b1;
`ifdef CCFF_LOADER_CRC_EN
                    err_nx     = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (accept) begin
                    shreg_nx = byte_data << 1;
                    head_nx  = byte_data[DATA_W-1];
                    en_nx    = 1'b1;
                    nbits_nx = (bit_cnt == LAST_BASE) ? NB_LAST : NB_FULL;
                    ready_nx = 1'b0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                bit_cnt_nx = bit_cnt + CNT_W'(1);
                if (nbits != '0) begin
                    head_nx  = shreg[DATA_W-1];
                    shreg_nx = shreg << 1;
                    nbits_nx = nbits - NB_W'(1);
                end else begin
                    en_nx = 1'b0;
                    if (bit_cnt < LAST_BIT) begin
                        state_nx = LOAD;
                        ready_nx = 1'b1;
                    end else begin
`ifdef CCFF_LOADER_CRC_EN
                        state_nx = CRC;
                        ready_nx = 1'b1;
`else
                        state_nx = DONE;
`endif
                    end
                end
            end
            CRC: begin
`ifdef CCFF_LOADER_CRC_EN
                // Trailer byte is compared only, never shifted
                if (accept) begin
                    err_nx   = (byte_data[7:0] != crc);
                    ready_nx = 1'b0;
                    state_nx = DONE;
                end
`else
                state_nx = IDLE;
`endif
            end
            DONE: begin
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state       <= IDLE;
            shreg       <= '0;
            nbits       <= '0;
            bit_cnt     <= '0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            byte_ready  <= 1'b0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            nbits       <= nbits_nx;
            bit_cnt     <= bit_cnt_nx;
            ccff_head   <= head_nx;
            ccff_clk_en <= en_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            byte_ready  <= ready_nx;
        end
    end

`ifdef CCFF_LOADER_CRC_EN
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nx;
        end
    end
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench for ccff_bitstream_loader against a bit-list model.
// Define CCFF_LOADER_CRC_EN to also exercise the CRC trailer check.
module tb_ccff_bitstream_loader;

`ifdef CCFF_LOADER_CRC_EN
    localparam int CL = 16;
`else
    localparam int CL = 12;
`endif
    localparam int DW = 8;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start;
    logic          byte_valid;
    logic [DW-1:0] byte_data;
    logic          byte_ready;
    logic          ccff_head;
    logic          ccff_clk_en;
    logic          busy;
    logic          done;
    logic          err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          en_cnt = 0;
    int          done_rises = 0;
    logic        done_d = 1'b0;
    logic [CL-1:0] chain = '0;
    logic        head_q[$];

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(
        .CHAIN_LEN (CL),
        .DATA_W    (DW)
    ) dut (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Chain model: captures ccff_head on every enabled edge
    always @(posedge prog_clk) begin
        if (ccff_clk_en === 1'b1) begin
            en_cnt++;
            chain = {chain[CL-2:0], ccff_head};
            head_q.push_back(ccff_head);
        end
        if (done === 1'b1 && done_d === 1'b0) done_rises++;
        done_d = done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First CL bits of the stream, first bit in the MSB
    function automatic logic [CL-1:0] ref_bits(input logic [7:0] b0,
                                               input logic [7:0] b1);
        logic [15:0] s;
        s = {b0, b1};
        return s[15 -: CL];
    endfunction

    function automatic logic [7:0] ref_crc(input logic [CL-1:0] bits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = CL - 1; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ (((c[7] ^ bits[i]) == 1'b1) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic clear_mon();
        en_cnt = 0;
        done_rises = 0;
        head_q.delete();
        chain = '0;
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (byte_ready !== 1'b1 && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        check(tag, 64'(t < 100), 64'd1);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        byte_valid = 1'b1;
        byte_data  = b;
        wait_ready(tag);
        @(negedge prog_clk);
    endtask

    task automatic run_load(input logic [7:0] b0, input logic [7:0] b1,
                            input int gap, input bit pulse,
                            input bit bad_crc);
        logic [CL-1:0] exp_bits;
        logic [CL-1:0] hv;
        logic [7:0]    trl;
        int            pre;
        exp_bits = ref_bits(b0, b1);
        trl      = ref_crc(exp_bits) ^ {7'd0, bad_crc};
        @(negedge prog_clk);
        clear_mon();
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_cleared", 64'(done), 64'd0);
        send(b0, "ready_b0");
        if (pulse) begin
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
            check("start_busy_ignored", 64'({busy, done}), 64'b10);
        end
        if (gap > 0) begin
            byte_valid = 1'b0;
            wait_ready("gap_ready");
            pre = en_cnt;
            for (int g = 0; g < gap; g++) begin
                check("gap_en_low", 64'(ccff_clk_en), 64'd0);
                @(negedge prog_clk);
            end
            check("gap_no_enables", 64'(en_cnt), 64'(pre));
        end
        send(b1, "ready_b1");
        byte_valid = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
        send(trl, "ready_trailer");
        byte_valid = 1'b0;
`endif
        begin
            int t;
            t = 0;
            while (done !== 1'b1 && t < 100) begin
                @(negedge prog_clk);
                t++;
            end
            check("done_timeout", 64'(t < 100), 64'd1);
        end
        hv = '0;
        for (int i = 0; i < head_q.size() && i < CL; i++) hv[CL-1-i] = head_q[i];
        check("enable_count", 64'(en_cnt), 64'(CL));
        check("head_sequence", 64'(hv), 64'(exp_bits));
        check("chain_model", 64'(chain), 64'(exp_bits));
        check("busy_end", 64'(busy), 64'd0);
        check("err_end", 64'(err), 64'(bad_crc));
        @(negedge prog_clk);
        check("done_rises_once", 64'(done_rises), 64'd1);
        check("done_held", 64'(done), 64'd1);
    endtask

    initial begin
        logic [7:0] r0, r1;
        pReset     = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        #12;
        check("reset_outputs",
              64'({byte_ready, ccff_head, ccff_clk_en, busy, done, err}), 64'd0);
        @(negedge prog_clk);
        pReset = 1'b0;
        @(negedge prog_clk);
        check("idle_outputs",
              64'({byte_ready, ccff_head, ccff_clk_en, busy, done, err}), 64'd0);

        run_load(8'hA5, 8'h3F, 0, 1'b0, 1'b0);
`ifndef CCFF_LOADER_CRC_EN
        begin
            logic [CL-1:0] hv;
            hv = '0;
            for (int i = 0; i < head_q.size() && i < CL; i++) hv[CL-1-i] = head_q[i];
            check("basic_pattern", 64'(hv), 64'(12'b1010_0101_0011));
        end
`endif
        run_load(8'hA5, 8'h3F, 5, 1'b0, 1'b0);
        run_load(8'hC3, 8'h5A, 0, 1'b1, 1'b0);

        // Valid in IDLE must not be taken
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        pre_idle_en : begin
            int pre;
            pre = en_cnt;
            repeat (3) @(negedge prog_clk);
            check("idle_ready_low", 64'(byte_ready), 64'd0);
            check("idle_no_enable", 64'(en_cnt), 64'(pre));
            check("idle_not_busy", 64'(busy), 64'd0);
        end
        byte_valid = 1'b0;

        // Reset in the middle of a load
        @(negedge prog_clk);
        clear_mon();
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        send(8'hFF, "ready_mid");
        byte_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (en_cnt < 5 && t < 50) begin
                @(negedge prog_clk);
                t++;
            end
            check("mid_load_reach", 64'(en_cnt), 64'd5);
        end
        #2 pReset = 1'b1;
        #1;
        check("midload_reset",
              64'({byte_ready, ccff_head, ccff_clk_en, busy, done, err}), 64'd0);
        @(negedge prog_clk);
        pReset = 1'b0;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        run_load(r0, r1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            run_load(r0, r1, int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end

`ifdef CCFF_LOADER_CRC_EN
        run_load(8'h12, 8'h34, 0, 1'b0, 1'b0);
        run_load(8'h12, 8'h34, 0, 1'b0, 1'b1);
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        run_load(r0, r1, 2, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
